// File: rtl/pipeline_credit_transmitter.sv
// rtl/pipeline_credit_transmitter.sv - credit-limited sender with registered, no-backpressure output
// Optional sticky overflow flag: define PIPELINE_CREDIT_TRANSMITTER_ERROR_EN.
module pipeline_credit_transmitter #(
  parameter  int WORD_WIDTH   = 33,
  parameter  int CREDIT_MAX   = 17,
  localparam int CREDIT_WIDTH = $clog2(CREDIT_MAX + 1)
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [WORD_WIDTH-1:0]   input_data,
  output logic                    output_valid,
  output logic [WORD_WIDTH-1:0]   output_data,
  input  logic                    credit_return,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    credits_all_home,
  output logic                    credit_error
);

  localparam logic [CREDIT_WIDTH-1:0] LP_MAX = CREDIT_WIDTH'(CREDIT_MAX);
  localparam logic [CREDIT_WIDTH-1:0] LP_ONE = CREDIT_WIDTH'(1);

  logic [CREDIT_WIDTH-1:0] r_count;
  logic                    r_valid;
  logic [WORD_WIDTH-1:0]   r_data;
  logic                    w_ready;
  logic                    w_send;
  logic                    w_at_max;

  // Ready depends only on the registered count, keeping valid/credit paths out of it.
  assign w_ready  = (r_count != '0);
  assign w_send   = input_valid && w_ready;
  assign w_at_max = (r_count == LP_MAX);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_count <= LP_MAX;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_send;
      if (w_send) begin
        r_data <= input_data;
      end
      if (w_send && !credit_return) begin
        r_count <= r_count - LP_ONE;
      end else if (!w_send && credit_return && !w_at_max) begin
        r_count <= r_count + LP_ONE;
      end
    end
  end

`ifdef PIPELINE_CREDIT_TRANSMITTER_ERROR_EN
  logic r_error;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_error <= 1'b0;
    end else if (credit_return && !w_send && w_at_max) begin
      r_error <= 1'b1;
    end
  end

  assign credit_error = r_error;
`else
  assign credit_error = 1'b0;
`endif

  assign input_ready      = w_ready;
  assign output_valid     = r_valid;
  assign output_data      = r_data;
  assign credit_count     = r_count;
  assign credits_all_home = w_at_max;

endmodule

// File: tb/tb_pipeline_credit_transmitter.sv
// tb/tb_pipeline_credit_transmitter.sv - randomized self-checking bench with credit/queue reference model
module tb_pipeline_credit_transmitter;

  localparam int WW  = 33;
  localparam int MAX = 17;
  localparam int CW  = $clog2(MAX + 1);

  logic          clock = 1'b0;
  logic          clear;
  logic          input_valid;
  logic          input_ready;
  logic [WW-1:0] input_data;
  logic          output_valid;
  logic [WW-1:0] output_data;
  logic          credit_return;
  logic [CW-1:0] credit_count;
  logic          credits_all_home;
  logic          credit_error;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: free receiver slots as an integer, last word seen on the wire
  int            m_credits;
  logic          m_valid;
  logic [WW-1:0] m_data;
  logic          m_err;

  pipeline_credit_transmitter #(.WORD_WIDTH(WW), .CREDIT_MAX(MAX)) dut (
    .clock            (clock),
    .clear            (clear),
    .input_valid      (input_valid),
    .input_ready      (input_ready),
    .input_data       (input_data),
    .output_valid     (output_valid),
    .output_data      (output_data),
    .credit_return    (credit_return),
    .credit_count     (credit_count),
    .credits_all_home (credits_all_home),
    .credit_error     (credit_error)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [WW-1:0] d, input logic r, input logic c);
    logic send;
    input_valid   = v;
    input_data    = d;
    credit_return = r;
    clear         = c;
    @(posedge clock);
    #1;
    if (c) begin
      m_credits = MAX;
      m_valid   = 1'b0;
      m_data    = '0;
      m_err     = 1'b0;
    end else begin
      send    = v && (m_credits > 0);
      m_valid = send;
      if (send) m_data = d;
      if (send && !r) m_credits = m_credits - 1;
      else if (r && !send) begin
        if (m_credits == MAX) begin
`ifdef PIPELINE_CREDIT_TRANSMITTER_ERROR_EN
          m_err = 1'b1;
`endif
        end else m_credits = m_credits + 1;
      end
    end
  endtask

  task automatic test_reset;
    drive(1'b1, WW'(5), 1'b1, 1'b1);
    drive(1'b1, WW'(6), 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    tests_run++; if (input_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", input_ready); end
    tests_run++; if (output_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", output_valid); end
    tests_run++; if (output_data !== '0) begin tests_failed++; $display("FAIL reset_data got %h want 0", output_data); end
    tests_run++; if (credit_count !== CW'(MAX)) begin tests_failed++; $display("FAIL reset_count got %0d want %0d", credit_count, MAX); end
    tests_run++; if (credits_all_home !== 1'b1) begin tests_failed++; $display("FAIL reset_all_home got %b want 1", credits_all_home); end
    tests_run++; if (credit_error !== 1'b0) begin tests_failed++; $display("FAIL reset_error got %b want 0", credit_error); end
  endtask

  task automatic test_burst;
    for (int i = 0; i < 20; i++) begin
      tests_run++; if (input_ready !== (i < MAX)) begin tests_failed++; $display("FAIL burst_ready[%0d] got %b want %b", i, input_ready, (i < MAX)); end
      drive(1'b1, WW'((i < MAX) ? i : MAX), 1'b0, 1'b0);
      tests_run++; if (output_valid !== (i < MAX)) begin tests_failed++; $display("FAIL burst_valid[%0d] got %b want %b", i, output_valid, (i < MAX)); end
      tests_run++; if (output_data !== WW'((i < MAX) ? i : MAX - 1)) begin tests_failed++; $display("FAIL burst_data[%0d] got %0d want %0d", i, output_data, (i < MAX) ? i : MAX - 1); end
      tests_run++; if (credit_count !== CW'((i < MAX) ? MAX - 1 - i : 0)) begin tests_failed++; $display("FAIL burst_count[%0d] got %0d", i, credit_count); end
    end
    tests_run++; if (input_ready !== 1'b0) begin tests_failed++; $display("FAIL burst_stalled_ready got %b want 0", input_ready); end
  endtask

  task automatic test_unblock;
    drive(1'b1, WW'(MAX), 1'b1, 1'b0);
    tests_run++; if (output_valid !== 1'b0) begin tests_failed++; $display("FAIL unblock_nosend got %b want 0", output_valid); end
    tests_run++; if (input_ready !== 1'b1) begin tests_failed++; $display("FAIL unblock_ready got %b want 1", input_ready); end
    tests_run++; if (credit_count !== CW'(1)) begin tests_failed++; $display("FAIL unblock_count got %0d want 1", credit_count); end
    drive(1'b1, WW'(MAX), 1'b0, 1'b0);
    tests_run++; if (output_valid !== 1'b1 || output_data !== WW'(MAX)) begin tests_failed++; $display("FAIL unblock_word valid %b data %0d want 1/%0d", output_valid, output_data, MAX); end
    tests_run++; if (credit_count !== '0) begin tests_failed++; $display("FAIL unblock_count0 got %0d want 0", credit_count); end
  endtask

  task automatic test_simultaneous;
    logic [WW-1:0] d;
    drive(1'b0, '0, 1'b1, 1'b0);
    d = WW'({$urandom(), $urandom()});
    drive(1'b1, d, 1'b1, 1'b0);
    tests_run++; if (output_valid !== 1'b1 || output_data !== d) begin tests_failed++; $display("FAIL simul_word valid %b data %h want 1/%h", output_valid, output_data, d); end
    tests_run++; if (credit_count !== CW'(1)) begin tests_failed++; $display("FAIL simul_count got %0d want 1", credit_count); end
    tests_run++; if (input_ready !== 1'b1) begin tests_failed++; $display("FAIL simul_ready got %b want 1", input_ready); end
  endtask

  task automatic test_overflow;
    logic exp_err;
`ifdef PIPELINE_CREDIT_TRANSMITTER_ERROR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++; if (credit_count !== CW'(MAX)) begin tests_failed++; $display("FAIL overflow_count got %0d want %0d", credit_count, MAX); end
    tests_run++; if (credit_error !== exp_err) begin tests_failed++; $display("FAIL overflow_error got %b want %b", credit_error, exp_err); end
    drive(1'b1, WW'(3), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++; if (credit_error !== exp_err) begin tests_failed++; $display("FAIL overflow_sticky got %b want %b", credit_error, exp_err); end
    drive(1'b0, '0, 1'b0, 1'b1);
    tests_run++; if (credit_error !== 1'b0) begin tests_failed++; $display("FAIL overflow_cleared got %b want 0", credit_error); end
  endtask

  task automatic test_clear_mid;
    for (int i = 0; i < MAX - 5; i++) drive(1'b1, WW'(100 + i), 1'b0, 1'b0);
    tests_run++; if (credit_count !== CW'(5)) begin tests_failed++; $display("FAIL clear_pre_count got %0d want 5", credit_count); end
    drive(1'b1, WW'(999), 1'b1, 1'b1);
    tests_run++; if (credit_count !== CW'(MAX)) begin tests_failed++; $display("FAIL clear_count got %0d want %0d", credit_count, MAX); end
    tests_run++; if (output_valid !== 1'b0) begin tests_failed++; $display("FAIL clear_valid got %b want 0", output_valid); end
    tests_run++; if (output_data !== '0) begin tests_failed++; $display("FAIL clear_data got %h want 0", output_data); end
  endtask

  task automatic test_random;
    logic v, r, c;
    logic [WW-1:0] d;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 63) == 0);
      d = WW'({$urandom(), $urandom()});
      tests_run++; if (input_ready !== (m_credits != 0)) begin tests_failed++; $display("FAIL rand_ready[%0d] got %b want %b", i, input_ready, (m_credits != 0)); end
      drive(v, d, r, c);
      tests_run++;
      if (output_valid !== m_valid || output_data !== m_data || credit_count !== CW'(m_credits)
          || credits_all_home !== (m_credits == MAX) || credit_error !== m_err) begin
        tests_failed++;
        $display("FAIL rand_state[%0d] got v%b d%h c%0d h%b e%b want v%b d%h c%0d h%b e%b", i,
                 output_valid, output_data, credit_count, credits_all_home, credit_error,
                 m_valid, m_data, m_credits, (m_credits == MAX), m_err);
      end
    end
  endtask

  initial begin
    m_credits = MAX; m_valid = 1'b0; m_data = '0; m_err = 1'b0;
    clear = 1'b1; input_valid = 1'b0; input_data = '0; credit_return = 1'b0;
    test_reset;
    test_burst;
    test_unblock;
    test_simultaneous;
    test_overflow;
    test_clear_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
